letc_core_muldiv_seq: RTL
=========================

Name: letc_core_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that owns the Execute stage's multicycle arithmetic resource. It accepts one MUL*/DIV*/REM* operation from Execute and runs a shared shift-add / restoring-divide datapath for XLEN iterations. It returns a single-cycle result strobe. Execute ties its e_ready to this block's ready output, so adhesive stalls the pipeline for the duration of the operation.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is $clog2(XLEN)+1.

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
start  input  1  request pulse from Execute; honoured only when ready=1
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operand_a  input  XLEN  rs1 value (post-forwarding)
operand_b  input  XLEN  rs2 value (post-forwarding)
flush  input  1  abort any in-flight operation
ready  output  1  high only in IDLE
result_valid  output  1  one-cycle strobe, result valid
result  output  XLEN  final value; held stable until the next accepted start

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- Reset: state=IDLE, ready=1, result_valid=0, result=0, counter=0.
- Accept: at the clock edge T with state=IDLE and start=1, the block latches op and operands.
  - Signed ops latch magnitudes plus the sign flags needed for the final correction.
  - start while ready=0 is ignored; no queueing.
- Special cases detected at accept skip CALC and go to DONE at T+1:
  - Divide by zero: DIV/DIVU → all ones (0xFFFFFFFF); REM/REMU → operand_a.
  - Signed overflow (operand_a=0x80000000, operand_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC: one iteration per cycle for XLEN cycles (T+1..T+XLEN).
  - Multiply: 2*XLEN-bit shift-add accumulator on unsigned magnitudes.
  - Divide: restoring, 1 quotient bit per cycle.
  - The counter decrements from XLEN; at 1 the state moves to FIXUP.
- FIXUP (T+XLEN+1): apply the sign correction.
  - MULH: negate the product if signs differ. MULHSU: operand_a sign only.
  - DIV: negate the quotient if signs differ. REM: remainder takes the dividend's sign.
  - Select the output half: MUL → low XLEN bits; MULH* → high XLEN bits; DIV*/REM* → quotient/remainder. Register into result.
- DONE (T+XLEN+2): result_valid=1 for exactly one cycle, then IDLE (ready=1 at T+XLEN+3).
  - Total accept-to-strobe latency: XLEN+2 cycles (34 for XLEN=32); special cases: 1 cycle.
- flush in any non-IDLE state: next state IDLE.
  - result_valid must not assert for the aborted op; result keeps its previous value.
  - flush in the same cycle as DONE suppresses result_valid.
  - flush in IDLE with start=1: flush wins, start is not accepted.
- Reset mid-operation returns all state to reset values on the next edge.
- Operands may change after accept without effect.
- Assertions (SIMULATION only):
  - ready, result_valid and state are never X after reset.
  - result_valid implies the previous state was CALC→FIXUP→DONE or a special-case path.
  - result_valid never asserts in two consecutive cycles.

Optional Feature:
LETC_CORE_MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle signed/unsigned 33x33 combinational multiplier. Accept at T goes straight to DONE at T+1 (latency 1). Divide ops are unchanged.
- Undefined: multiplies use the iterative CALC/FIXUP path (latency XLEN+2), and no hardware multiplier is inferred.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB strobed 34 cycles after accept (1 cycle with FAST_MUL); ready low throughout, back high the cycle after the strobe.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 ÷ 2 → 0xFFFFFFFD; REM −7 ÷ 2 → 0xFFFFFFFF; DIVU 100 ÷ 7 → 14; REMU → 2; each with a 34-cycle latency.
- DIV 5 ÷ 0 → 0xFFFFFFFF and REMU 5 ÷ 0 → 5 in 1 cycle; DIV 0x80000000 ÷ −1 → 0x80000000 and REM → 0 in 1 cycle.
- Start a DIVU, assert flush at iteration 10 → no result_valid, ready=1 next cycle; an immediate new DIVU 9 ÷ 3 → 3 at normal latency.
- Pulse start repeatedly while busy, and assert rst_n=0 mid-CALC → extra starts ignored; after reset ready=1, result=0, result_valid=0.

Source files
------------

// File: rtl/letc_core_muldiv_seq.sv
// rtl/letc_core_muldiv_seq.sv - iterative RV32M multiply/divide sequencer (shift-add / restoring divide)
// Optional: LETC_CORE_MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL* ops.
module letc_core_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_hi, r_lo, r_b, r_result;

  logic              w_accept, w_a_sgn, w_b_sgn, w_div_zero, w_ovf, w_fast, w_special;
  logic [XLEN-1:0]   w_ma, w_mb, w_spec_val, w_fix_val, w_diff;
  logic [XLEN:0]     w_sum, w_rem_sh;
  logic              w_ge;
  logic [2*XLEN-1:0] w_prod_fix;

  // Accept-time decode: magnitudes, sign flags and single-cycle special results
  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_a_sgn    = operand_a[XLEN-1] & (op[2] ? !op[0] : (op == 3'd1 || op == 3'd2));
  assign w_b_sgn    = operand_b[XLEN-1] & (op[2] ? !op[0] : (op == 3'd1));
  assign w_ma       = w_a_sgn ? -operand_a : operand_a;
  assign w_mb       = w_b_sgn ? -operand_b : operand_b;
  assign w_div_zero = op[2] && (operand_b == '0);
  assign w_ovf      = op[2] && !op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (operand_b == '1);

`ifdef LETC_CORE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
  assign w_fast  = !op[2];
  assign w_fa    = {{XLEN{w_a_sgn}}, operand_a};
  assign w_fb    = {{XLEN{w_b_sgn}}, operand_b};
  assign w_fprod = w_fa * w_fb;
`else
  assign w_fast  = 1'b0;
`endif

  assign w_special = w_div_zero || w_ovf || w_fast;

  always_comb begin
    w_spec_val = '0;
    if (w_div_zero)
      w_spec_val = op[1] ? operand_a : '1;
    else if (w_ovf)
      w_spec_val = op[1] ? '0 : operand_a;
`ifdef LETC_CORE_MULDIV_FAST_MUL_EN
    if (w_fast)
      w_spec_val = (op == 3'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif
  end

  // Shared iteration datapath: r_hi/r_lo hold product or remainder/quotient
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_b};
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;

  assign w_prod_fix = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

  always_comb begin
    w_fix_val = '0;
    if (r_op[2])
      w_fix_val = r_op[1] ? (r_neg ? -r_hi : r_hi) : (r_neg ? -r_lo : r_lo);
    else
      w_fix_val = (r_op == 3'd0) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (r_cnt == CW'(1)) w_next = S_FIXUP;
      S_FIXUP: w_next = flush ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready        = (r_state == S_IDLE);
    result_valid = (r_state == S_DONE) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_neg <= (op[2] && op[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
      r_cnt <= CW'(XLEN);
      r_hi  <= '0;
      r_lo  <= op[2] ? w_ma : w_mb;
      r_b   <= op[2] ? w_mb : w_ma;
      if (w_special) r_result <= w_spec_val;
    end else if (r_state == S_CALC && !flush) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op[2]) begin
        r_hi <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (r_state == S_FIXUP && !flush) begin
      r_result <= w_fix_val;
    end
  end

  assign result = r_result;

`ifdef SIMULATION
  state_t r_prev_state;
  logic   r_prev_valid;
  always_ff @(posedge clk) begin
    r_prev_state <= r_state;
    r_prev_valid <= result_valid;
    if (rst_n) begin
      assert (!$isunknown({ready, result_valid, r_state}));
      if (result_valid) assert (r_prev_state == S_FIXUP || r_prev_state == S_IDLE);
      assert (!(result_valid && r_prev_valid));
    end
  end
`endif
endmodule
